add_arbiter: RTL
================

# add_arbiter

Round-robin arbiter that shares one 2-stage adder pipeline among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready channels and tags each issued operation with its requester index. Results return on a single shared response channel with backpressure. It sits between several accelerator front-ends and the single adder datapath, and sustains one addition per cycle when the response consumer is always ready.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `WIDTH`, 32: operand and result width.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  NREQ×WIDTH  operand A, per requester.
- `req_b`  in  NREQ×WIDTH  operand B, per requester.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  $clog2(NREQ)  index of the originating requester.
- `rsp_y`  out  WIDTH  sum (a+b) mod 2^WIDTH.
- `rsp_carry`  out  1  carry-out of the sum.
- `busy`  out  1  at least one operation outstanding (pipe or FIFO).

## Operation
- **Grant selection (combinational):**
  - Starting at pointer `ptr`, scan indices ptr, ptr+1, …, NREQ-1, 0, …, wrapping.
  - The first index `g` with `req_valid[g]` is granted.
  - `req_ready[g]` = credit_ok. All other `req_ready` bits are 0.
- **Transfer:** occurs on `req_valid[g] && req_ready[g]`.
  - On transfer: {g, req_a[g], req_b[g]} enter the pipe, and `ptr <= (g+1) mod NREQ`.
  - With no transfer, `ptr` holds.
- **Pipe (add_pipe):**
  - Stage 1 registers operands and id.
  - Stage 2 registers the WIDTH+1-bit sum and id.
  - The pipe never stalls.
- **Result FIFO:**
  - Depth `FIFO_DEPTH` = 3 (pipe depth + 1).
  - Written when the stage-2 valid is set.
  - Head drives `rsp_*`. Popped on `rsp_valid && rsp_ready`.
- **Credits:**
  - `outstanding` = s1_valid + s2_valid + fifo_count.
  - credit_ok = (outstanding − pop) < FIFO_DEPTH.
  - This guarantees a FIFO write never meets a full FIFO; no result is ever dropped.
- **Arithmetic:** unsigned. `rsp_y` wraps modulo 2^WIDTH; `rsp_carry` is bit WIDTH.
- **busy** = (outstanding != 0).
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_y` = 0, `rsp_carry` = 0, `busy` = 0.
  - `ptr` = 0; pipe valids cleared; FIFO emptied.

## Timing
- **Latency:** accept at cycle T → stage 1 in T+1 → stage 2 in T+2 → `rsp_valid` in T+3 (FIFO previously empty).
- **Throughput:** 1 op/cycle with `rsp_ready` held high.
- **Backpressure:** with `rsp_ready` low, at most 3 accepts occur; then all `req_ready` stay 0 until a pop.
  - A pop in cycle C allows an accept in the same cycle C.
- **Response rules:**
  - Results are returned in accept order, which is global FIFO order.
  - `rsp_*` stays stable while `rsp_valid && !rsp_ready`.
- **Request rules:**
  - A requester must hold `req_a`/`req_b` stable while valid and not ready.
  - A requester may drop valid without a transfer; the grant then moves on combinationally.
- **Simultaneous events:** FIFO write and pop in the same cycle are both performed; the count is unchanged.
- **Reset mid-operation:** all in-flight and FIFO results are discarded, with no `rsp_valid` in the cycle after reset. `ptr` returns to 0.
- **Single requester:** a single active requester may be granted every cycle; after its transfer, `ptr` wraps past it.

## Structure
- **Package `add_arbiter_pkg`:**
  - `PIPE_DEPTH` = 2 and `FIFO_DEPTH` = PIPE_DEPTH+1.
  - Struct type `add_rsp_t` {id, y, carry}, parameterised through the package defaults WIDTH=32, NREQ=4.
- **Sub-module `add_pipe`:**
  - 2-stage registered adder carrying valid and id alongside the data.
  - Synchronous reset clears the valids only.
- **Kept inline in add_arbiter:** the round-robin grant, credit logic and the 3-entry circular FIFO (read/write pointers, count).

## Test plan
- **Single op:** reset, then req_valid[2]=1, a=5, b=7 → transfer in cycle 0; rsp_valid in cycle 3 with id=2, y=12, carry=0; busy high for cycles 1–3.
- **Round-robin fairness:** all 4 requesters valid continuously, rsp_ready=1 → grants 0,1,2,3,0,…, one per cycle; rsp_id follows the same order 3 cycles later.
- **Wrap and carry:** a=0xFFFF_FFFF, b=2 → y=0x0000_0001, carry=1.
- **Backpressure:** rsp_ready=0 with requesters 0 and 1 always valid → exactly 3 accepts, then req_ready=0. Raise rsp_ready → 3 results drain in order, with a new accept in the first pop cycle and no loss or duplication.
- **Reset mid-flight:** accept 2 ops, assert reset in the following cycle → no rsp_valid afterwards, busy=0, ptr=0; the next op from requester 3 is granted normally.
- **Stability:** hold rsp_ready=0 for 5 cycles while rsp_valid=1 → rsp_id/y/carry unchanged; a stalled requester sees req_ready=0 until a credit frees.

Source files
------------

// File: rtl/add_arbiter_pkg.sv
// rtl/add_arbiter_pkg.sv - shared constants and types for the add arbiter
//
// Purpose: pipeline/FIFO sizing shared by add_arbiter and add_pipe, plus a
// response record type sized for the default configuration (32-bit, 4 req).
package add_arbiter_pkg;

  localparam int PIPE_DEPTH = 2;
  // One extra entry lets a result leave the pipe in the same cycle that the
  // head is still waiting for the consumer.
  localparam int FIFO_DEPTH = PIPE_DEPTH + 1;

  localparam int PKG_WIDTH = 32;
  localparam int PKG_NREQ  = 4;

  typedef struct packed {
    logic [$clog2(PKG_NREQ)-1:0] id;
    logic [PKG_WIDTH-1:0]        y;
    logic                        carry;
  } add_rsp_t;

endpackage

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - two-stage registered adder carrying valid and id
//
// Purpose: stage 1 captures operands and id, stage 2 holds the WIDTH+1-bit
// sum and id. Never stalls; reset clears only the valid bits.
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   in_valid/id/a/b     operation entering stage 1
//   s1_valid            stage-1 occupancy (used for credit counting)
//   out_valid/id/sum    stage-2 result; sum[WIDTH] is the carry-out
module add_pipe
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDW-1:0]   in_id,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             s1_valid,
  output logic             out_valid,
  output logic [IDW-1:0]   out_id,
  output logic [WIDTH:0]   out_sum
);

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IDW-1:0]   s1_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // Data registers are not reset; valids qualify them.
  always_ff @(posedge clock) begin
    s1_a    <= in_a;
    s1_b    <= in_b;
    s1_id   <= in_id;
    out_sum <= {1'b0, s1_a} + {1'b0, s1_b};
    out_id  <= s1_id;
  end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one adder pipeline
//
// Purpose: grants one of NREQ requesters per cycle (round-robin from ptr),
// pushes the operands through add_pipe and returns tagged results in accept
// order through a 3-entry FIFO with backpressure.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   req_valid/req_ready          per-requester handshake (ready one-hot)
//   req_a, req_b                 packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready          shared result handshake
//   rsp_id, rsp_y, rsp_carry     originating requester, sum, carry-out
//   busy                         any operation in the pipe or FIFO
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     rsp_carry,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDW:0]  NREQ_W    = (IDW+1)'(NREQ);
  localparam logic [PW-1:0] FIFO_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   FIFO_FULL = (CW+1)'(FIFO_DEPTH);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int step);
    logic [IDW:0] s;
    s = {1'b0, base} + (IDW+1)'(step);
    if (s >= NREQ_W) s = s - NREQ_W;
    return s[IDW-1:0];
  endfunction

  function automatic logic [PW-1:0] fifo_next(input logic [PW-1:0] p);
    return (p == FIFO_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [IDW-1:0]   ptr;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             transfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             s1_valid;
  logic             s2_valid;
  logic [IDW-1:0]   s2_id;
  logic [WIDTH:0]   s2_sum;

  logic [IDW-1:0]   fifo_id  [FIFO_DEPTH];
  logic [WIDTH:0]   fifo_sum [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    fifo_count;

  logic [CW:0]      outstanding;
  logic             pop;
  logic             credit_ok;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[wrap_idx(ptr, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(ptr, k);
      end
    end
  end

  // Every operation in flight owns a FIFO slot; a same-cycle pop frees one,
  // so a result leaving the pipe can never find the FIFO full.
  assign pop         = rsp_valid && rsp_ready;
  assign outstanding = (CW+1)'(s1_valid) + (CW+1)'(s2_valid) + {1'b0, fifo_count};
  assign credit_ok   = (outstanding - (CW+1)'(pop)) < FIFO_FULL;
  assign busy        = (outstanding != '0);

  always_comb begin
    req_ready = '0;
    if (grant_found && credit_ok && !reset) req_ready[grant_idx] = 1'b1;
  end

  assign transfer = |req_ready;
  assign sel_a    = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b    = req_b[grant_idx*WIDTH +: WIDTH];

  add_pipe #(
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (transfer),
    .in_id     (grant_idx),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .s1_valid  (s1_valid),
    .out_valid (s2_valid),
    .out_id    (s2_id),
    .out_sum   (s2_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (transfer) ptr <= wrap_idx(grant_idx, 1);
      if (s2_valid) wr_ptr <= fifo_next(wr_ptr);
      if (pop) rd_ptr <= fifo_next(rd_ptr);
      fifo_count <= fifo_count + CW'(s2_valid) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (s2_valid) begin
      fifo_id[wr_ptr]  <= s2_id;
      fifo_sum[wr_ptr] <= s2_sum;
    end
  end

  // Storage is not reset, so the response fields read as zero when empty.
  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
  assign rsp_y     = rsp_valid ? fifo_sum[rd_ptr][WIDTH-1:0] : '0;
  assign rsp_carry = rsp_valid && fifo_sum[rd_ptr][WIDTH];

endmodule
